// File: rtl/aes_cipher.sv
// Iterative AES-128 encryption core: one full round plus one key-expansion step per clock.
// The host pulses ld with key/text_in, then reads text_out while done is high.
module aes_sbox (
   input  logic [7:0] a_i,
   output logic [7:0] y_o
);
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry 0 sits in the top byte, so the bit offset of entry a is (255-a)*8.
   assign y_o = SBOX_TABLE[{~a_i, 3'b000} +: 8];
endmodule

module aes_cipher (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   output logic         done,
   input  logic [127:0] key,
   input  logic [127:0] text_in,
   output logic [127:0] text_out
);
   logic [127:0] state_q, state_d;
   logic [127:0] rkey_q, rkey_d;
   logic [127:0] text_out_q, text_out_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         done_q, done_d;

   logic [127:0] sub_v, shf_v, mix_v, rnd_v;
   logic [31:0]  kw_rot, kw_sub, kw_t;
   logic [31:0]  kn0, kn1, kn2, kn3;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // The counter runs 10..1, so round n uses the constant for counter value 11-n.
   function automatic logic [7:0] rcon(input logic [3:0] cnt);
      case (cnt)
         4'd10:   return 8'h01;
         4'd9:    return 8'h02;
         4'd8:    return 8'h04;
         4'd7:    return 8'h08;
         4'd6:    return 8'h10;
         4'd5:    return 8'h20;
         4'd4:    return 8'h40;
         4'd3:    return 8'h80;
         4'd2:    return 8'h1b;
         4'd1:    return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_sub
         aes_sbox u_sbox (
            .a_i (state_q[127-8*gi -: 8]),
            .y_o (sub_v[127-8*gi -: 8])
         );
         // Byte 4c+r takes the substituted byte from column (c+r) mod 4 of the same row.
         assign shf_v[127-8*gi -: 8] =
            sub_v[127-8*(4*(((gi/4) + (gi%4)) % 4) + (gi%4)) -: 8];
      end
      for (gi = 0; gi < 4; gi++) begin : g_col
         assign mix_v[127-32*gi -: 32] = mix_col(shf_v[127-32*gi -: 32]);
         aes_sbox u_ksbox (
            .a_i (kw_rot[31-8*gi -: 8]),
            .y_o (kw_sub[31-8*gi -: 8])
         );
      end
   endgenerate

   assign kw_rot = {rkey_q[23:0], rkey_q[31:24]};
   assign kw_t   = kw_sub ^ {rcon(cnt_q), 24'h000000};
   assign kn0    = rkey_q[127:96] ^ kw_t;
   assign kn1    = rkey_q[95:64]  ^ kn0;
   assign kn2    = rkey_q[63:32]  ^ kn1;
   assign kn3    = rkey_q[31:0]   ^ kn2;
   assign rnd_v  = ((cnt_q == 4'd1) ? shf_v : mix_v) ^ {kn0, kn1, kn2, kn3};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= '0;
         rkey_q     <= '0;
         text_out_q <= '0;
         cnt_q      <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         rkey_q     <= rkey_d;
         text_out_q <= text_out_d;
         cnt_q      <= cnt_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      rkey_d     = rkey_q;
      text_out_d = text_out_q;
      cnt_d      = cnt_q;
      done_d     = 1'b0;
      if (cnt_q != 4'd0) begin
         state_d = rnd_v;
         rkey_d  = {kn0, kn1, kn2, kn3};
         cnt_d   = cnt_q - 4'd1;
         if (cnt_q == 4'd1) begin
            text_out_d = rnd_v;
            done_d     = 1'b1;
         end
      end
      // A load overrides the round update but not a completion on the same edge.
      if (ld) begin
         state_d = text_in ^ key;
         rkey_d  = key;
         cnt_d   = 4'd10;
      end
   end

   always_comb begin
      done     = done_q;
      text_out = text_out_q;
   end
endmodule

// File: tb/tb_aes_cipher.sv
// Bench for aes_cipher: fixed FIPS-197 vectors plus random vectors against a byte-level
// AES model whose S-box is derived from GF(2^8) inversion and the affine map.
module tb_aes_cipher;
   logic         clk;
   logic         rst;
   logic         ld;
   logic         done;
   logic [127:0] key;
   logic [127:0] text_in;
   logic [127:0] text_out;

   int           n_checks;
   int           n_pass;
   logic [127:0] last_ct;
   logic [7:0]   sb_ref [256];

   localparam logic [127:0] V1_CT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
   localparam logic [127:0] V2_CT = 128'hf795bd4a52e29ed713d313fa20e98dbc;
   localparam logic [127:0] V3_K  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] V3_P  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] V3_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] V4_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] V4_P  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] V4_CT = 128'h3925841d02dc09fbdc118597196a0b32;

   aes_cipher dut (
      .clk      (clk),
      .rst      (rst),
      .ld       (ld),
      .done     (done),
      .key      (key),
      .text_in  (text_in),
      .text_out (text_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sb_ref[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [127:0] ref_aes(input logic [127:0] k, input logic [127:0] p);
      logic [7:0] w [176];
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] tmp [4];
      logic [7:0] coef [4];
      logic [7:0] rc, x, acc;
      logic [127:0] r;
      coef = '{8'h02, 8'h03, 8'h01, 8'h01};
      for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
      rc = 8'h01;
      for (int i = 16; i < 176; i += 4) begin
         for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
         if (i % 16 == 0) begin
            x      = tmp[0];
            tmp[0] = sb_ref[tmp[1]] ^ rc;
            tmp[1] = sb_ref[tmp[2]];
            tmp[2] = sb_ref[tmp[3]];
            tmp[3] = sb_ref[x];
            rc     = gmul(rc, 8'h02);
         end
         for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
      end
      for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) t[i] = sb_ref[s[4*(((i/4) + (i%4)) % 4) + (i%4)]];
         for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) begin
               if (rnd < 10) begin
                  acc = 8'h00;
                  for (int kk = 0; kk < 4; kk++) acc = acc ^ gmul(coef[(kk - rr + 4) % 4], t[4*c+kk]);
               end else begin
                  acc = t[4*c+rr];
               end
               s[4*c+rr] = acc ^ w[16*rnd + 4*c + rr];
            end
      end
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = s[i];
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic load_once(input logic [127:0] k, input logic [127:0] p);
      key     = k;
      text_in = p;
      ld      = 1'b1;
      @(negedge clk);
      ld      = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            lat = i;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; ld = 1'b0; key = '0; text_in = '0;
      repeat (3) @(negedge clk);
      n_checks++;
      if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done);
      else n_pass++;
      n_checks++;
      if (text_out !== 128'h0) $display("FAIL reset_text_out: got %h expected 0", text_out);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      last_ct = '0;
   endtask

   task automatic test_ld_held();
      int lat;
      int pulses;
      key = '0; text_in = '0; ld = 1'b1;
      repeat (2) @(negedge clk);
      ld = 1'b0;
      wait_done(lat);
      n_checks++;
      if (lat !== 10) $display("FAIL ld_held_latency: got %0d expected 10", lat);
      else n_pass++;
      n_checks++;
      if (text_out !== V1_CT) $display("FAIL ld_held_ct: got %h expected %h", text_out, V1_CT);
      else n_pass++;
      pulses = 0;
      repeat (15) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses !== 0) $display("FAIL ld_held_extra_done: got %0d extra pulses expected 0", pulses);
      else n_pass++;
      last_ct = V1_CT;
      $display("txn ld_held key=%h pt=%h ct=%h", 128'h0, 128'h0, text_out);
   endtask

   task automatic test_vector(input string nm, input logic [127:0] k, input logic [127:0] p,
                              input logic [127:0] exp);
      int lat;
      load_once(k, p);
      wait_done(lat);
      n_checks++;
      if (lat !== 10) $display("FAIL %s_latency: got %0d expected 10", nm, lat);
      else n_pass++;
      n_checks++;
      if (text_out !== exp) $display("FAIL %s_ct: got %h expected %h", nm, text_out, exp);
      else n_pass++;
      @(negedge clk);
      n_checks++;
      if (done !== 1'b0) $display("FAIL %s_pulse_width: got done=%b expected 0", nm, done);
      else n_pass++;
      n_checks++;
      if (text_out !== exp) $display("FAIL %s_hold: got %h expected %h", nm, text_out, exp);
      else n_pass++;
      last_ct = exp;
      $display("txn %s key=%h pt=%h ct=%h", nm, k, p, text_out);
   endtask

   task automatic test_idle();
      for (int i = 0; i < 5; i++) begin
         key = rand128(); text_in = rand128(); ld = 1'b0;
         @(negedge clk);
         n_checks++;
         if (done !== 1'b0 || text_out !== last_ct)
            $display("FAIL idle_hold: got done=%b ct=%h expected done=0 ct=%h", done, text_out, last_ct);
         else n_pass++;
      end
   endtask

   task automatic test_random();
      logic [127:0] k, p;
      for (int i = 0; i < 12; i++) begin
         k = rand128();
         p = rand128();
         test_vector($sformatf("rand%0d", i), k, p, ref_aes(k, p));
      end
   endtask

   task automatic test_restart();
      int pulses;
      int lat;
      logic [127:0] prev;
      test_vector("v3", V3_K, V3_P, V3_CT);
      prev = last_ct;
      load_once(V1_CT, V2_CT);
      repeat (4) @(negedge clk);
      load_once(V4_K, V4_P);
      pulses = 0;
      lat = -1;
      for (int i = 1; i <= 25; i++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            pulses++;
            if (lat < 0) lat = i;
         end else if (lat < 0 && text_out !== prev) begin
            n_checks++;
            $display("FAIL restart_text_out_early: got %h expected %h", text_out, prev);
         end
      end
      n_checks++;
      if (pulses !== 1) $display("FAIL restart_pulses: got %0d expected 1", pulses);
      else n_pass++;
      n_checks++;
      if (lat !== 10) $display("FAIL restart_latency: got %0d expected 10", lat);
      else n_pass++;
      n_checks++;
      if (text_out !== V4_CT) $display("FAIL restart_ct: got %h expected %h", text_out, V4_CT);
      else n_pass++;
      last_ct = V4_CT;
      $display("txn restart key=%h pt=%h ct=%h", V4_K, V4_P, text_out);
   endtask

   task automatic test_back_to_back();
      int lat;
      load_once('0, '0);
      repeat (9) @(negedge clk);
      load_once('0, V1_CT);
      n_checks++;
      if (done !== 1'b1 || text_out !== V1_CT)
         $display("FAIL b2b_first: got done=%b ct=%h expected done=1 ct=%h", done, text_out, V1_CT);
      else n_pass++;
      $display("txn b2b_first key=%h pt=%h ct=%h", 128'h0, 128'h0, text_out);
      wait_done(lat);
      n_checks++;
      if (lat !== 10) $display("FAIL b2b_spacing: got %0d expected 10", lat);
      else n_pass++;
      n_checks++;
      if (text_out !== V2_CT) $display("FAIL b2b_second: got %h expected %h", text_out, V2_CT);
      else n_pass++;
      last_ct = V2_CT;
      $display("txn b2b_second key=%h pt=%h ct=%h", 128'h0, V1_CT, text_out);
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      int pulses;
      load_once(rand128(), rand128());
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (text_out !== 128'h0 || done !== 1'b0)
         $display("FAIL reset_mid_async: got done=%b ct=%h expected done=0 ct=0", done, text_out);
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      pulses = 0;
      repeat (15) begin
         @(negedge clk);
         if (done === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses !== 0) $display("FAIL reset_mid_pulses: got %0d expected 0", pulses);
      else n_pass++;
      n_checks++;
      if (text_out !== 128'h0) $display("FAIL reset_mid_ct: got %h expected 0", text_out);
      else n_pass++;
      $display("txn reset_mid ct=%h", text_out);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      last_ct  = '0;
      build_sbox();
      test_reset();
      test_ld_held();
      test_vector("v2", 128'h0, V1_CT, V2_CT);
      test_vector("v3", V3_K, V3_P, V3_CT);
      test_vector("v4", V4_K, V4_P, V4_CT);
      test_idle();
      test_random();
      test_restart();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
